// File: rtl/apb_i2c.sv
// APB-programmable single-master I2C controller with a command FIFO and an RX FIFO.
// Each command moves one DATA_W-bit word, MSB first, to or from the slave addressed in CONFIG.
module apb_i2c #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [DATA_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic              PWRITE,
    input  logic              PSELx,
    input  logic              PENABLE,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              INT_TX,
    output logic              INT_RX,
    output logic              SDA_ENABLE,
    output logic              SCL_ENABLE,
    inout  wire               SDA,
    inout  wire               SCL
);
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StAddrAck, StData, StDataAck, StStop
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cfg;
    logic [DATA_W-1:0] r_clkdiv, r_div_act, r_cnt, r_data;
    logic              r_nack, r_is_read, r_smp, r_abort;
    logic [1:0]        r_phase;
    logic [2:0]        r_bit;
    logic [BW-1:0]     r_byte;
    logic [7:0]        r_addr;

    logic [DATA_W:0]   r_cmd_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_rx_mem  [FIFO_DEPTH];
    logic [AW-1:0]     r_cmd_wr, r_cmd_rd, r_rx_wr, r_rx_rd;
    logic [CW-1:0]     r_cmd_cnt, r_rx_cnt;

    logic w_acc, w_a_tx, w_a_rx, w_a_cfg, w_a_st, w_a_div, w_err, w_ok_wr, w_ok_rd;
    logic w_cmd_full, w_cmd_empty, w_rx_full, w_rx_empty, w_cmd_push, w_rx_pop;
    logic w_start, w_set_nack, w_rx_push, w_qend, w_bit_end, w_last;
    logic w_scl_o, w_sda_o, w_scl_en, w_sda_en;
    logic [DATA_W:0]   w_cmd_head;
    logic [5:0]        w_status;
    logic [DATA_W-1:0] w_rdata;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_acc       = PSELx & PENABLE;
    assign w_a_tx      = (PADDR == DATA_W'(32'h00));
    assign w_a_rx      = (PADDR == DATA_W'(32'h04));
    assign w_a_cfg     = (PADDR == DATA_W'(32'h08));
    assign w_a_st      = (PADDR == DATA_W'(32'h0C));
    assign w_a_div     = (PADDR == DATA_W'(32'h10));
    assign w_cmd_full  = (r_cmd_cnt == CW'(FIFO_DEPTH));
    assign w_cmd_empty = (r_cmd_cnt == '0);
    assign w_rx_full   = (r_rx_cnt == CW'(FIFO_DEPTH));
    assign w_rx_empty  = (r_rx_cnt == '0);
    assign w_cmd_head  = r_cmd_mem[r_cmd_rd];
    assign w_status    = {r_nack, w_rx_full, w_rx_empty, w_cmd_empty, w_cmd_full,
                          r_state != StIdle};

    always_comb begin
        w_err = 1'b0;
        if (w_acc) begin
            if (!(w_a_tx || w_a_rx || w_a_cfg || w_a_st || w_a_div)) w_err = 1'b1;
            else if (PWRITE && (w_a_tx || w_a_rx) && w_cmd_full)     w_err = 1'b1;
            else if (!PWRITE && w_a_rx && w_rx_empty)                 w_err = 1'b1;
        end
    end

    assign w_ok_wr    = w_acc & PWRITE & ~w_err;
    assign w_ok_rd    = w_acc & ~PWRITE & ~w_err;
    assign w_cmd_push = w_ok_wr & (w_a_tx | w_a_rx);
    assign w_rx_pop   = w_ok_rd & w_a_rx;

    always_comb begin
        w_rdata = '0;
        if (w_ok_rd) begin
            if (w_a_rx)       w_rdata = r_rx_mem[r_rx_rd];
            else if (w_a_cfg) w_rdata = DATA_W'(r_cfg);
            else if (w_a_st)  w_rdata = DATA_W'(w_status);
            else if (w_a_div) w_rdata = r_clkdiv;
        end
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign PRDATA     = PRESETn ? '0 : w_rdata;
    assign PSLVERR    = ~PRESETn & w_err;
    assign PREADY     = 1'b1;
    assign INT_TX     = ~PRESETn & r_cfg[0] & w_cmd_empty;
    assign INT_RX     = ~PRESETn & ~w_rx_empty;
    assign SDA_ENABLE = ~PRESETn & w_sda_en;
    assign SCL_ENABLE = ~PRESETn & w_scl_en;
    assign SDA        = SDA_ENABLE ? w_sda_o : 1'bz;
    assign SCL        = SCL_ENABLE ? w_scl_o : 1'bz;

    assign w_qend    = (r_cnt == r_div_act);
    assign w_bit_end = w_qend && (r_phase == 2'd3) && (r_state != StIdle);
    assign w_last    = (r_byte == BW'(NBYTES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_scl_o     = r_phase[1];
        w_sda_o     = 1'b1;
        w_scl_en    = 1'b1;
        w_sda_en    = 1'b1;
        w_start     = 1'b0;
        w_set_nack  = 1'b0;
        w_rx_push   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_scl_en = 1'b0;
                w_sda_en = 1'b0;
                if (r_cfg[0] && !w_cmd_empty) begin
                    w_state_nxt = StStart;
                    w_start     = 1'b1;
                end
            end
            StStart: begin
                // SCL stays high; SDA falls halfway through the period.
                w_scl_o = 1'b1;
                w_sda_o = ~r_phase[1];
                if (w_bit_end) w_state_nxt = StAddr;
            end
            StAddr: begin
                w_sda_o = r_addr[3'd7 - r_bit];
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = StAddrAck;
            end
            StAddrAck: begin
                w_sda_en = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = r_smp ? StStop : StData;
                    w_set_nack  = r_smp;
                end
            end
            StData: begin
                w_sda_en = ~r_is_read;
                w_sda_o  = r_data[DATA_W-1];
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = StDataAck;
            end
            StDataAck: begin
                w_sda_en = r_is_read;
                w_sda_o  = w_last;
                if (w_bit_end) begin
                    if (!r_is_read && r_smp) begin
                        w_state_nxt = StStop;
                        w_set_nack  = 1'b1;
                    end else begin
                        w_state_nxt = w_last ? StStop : StData;
                    end
                end
            end
            StStop: begin
                w_sda_o = (r_phase == 2'd3);
                if (w_bit_end) begin
                    w_state_nxt = StIdle;
                    if (r_is_read && !r_abort) begin
                        w_rx_push  = ~w_rx_full;
                        w_set_nack = w_rx_full;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_phase   <= '0;
            r_div_act <= DATA_W'(4);
            r_bit     <= '0;
            r_byte    <= '0;
            r_data    <= '0;
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_smp     <= 1'b1;
            r_abort   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle) begin
                r_cnt   <= '0;
                r_phase <= '0;
            end else if (w_qend) begin
                r_cnt   <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_cnt <= r_cnt + DATA_W'(1);
            end
            if (w_start) begin
                r_div_act <= r_clkdiv;
                r_data    <= w_cmd_head[DATA_W-1:0];
                r_is_read <= w_cmd_head[DATA_W];
                r_addr    <= {r_cfg[7:1], w_cmd_head[DATA_W]};
                r_bit     <= '0;
                r_byte    <= '0;
                r_abort   <= 1'b0;
            end
            // Mid-high of SCL: end of the third quarter.
            if (r_state != StIdle && w_qend && r_phase == 2'd2) r_smp <= SDA;
            if (w_bit_end) begin
                if (r_state == StAddr || r_state == StData) r_bit <= r_bit + 3'd1;
                if (r_state == StData) r_data <= {r_data[DATA_W-2:0], r_smp};
                if (r_state == StDataAck) r_byte <= r_byte + BW'(1);
                if (r_state == StAddrAck && r_smp) r_abort <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            r_cfg     <= '0;
            r_clkdiv  <= DATA_W'(4);
            r_nack    <= 1'b0;
            r_cmd_wr  <= '0;
            r_cmd_rd  <= '0;
            r_cmd_cnt <= '0;
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_ok_wr && w_a_cfg) r_cfg <= PWDATA[7:0];
            if (w_ok_wr && w_a_div) r_clkdiv <= PWDATA;
            if (w_ok_wr && w_a_st && PWDATA[5]) r_nack <= 1'b0;
            if (w_set_nack) r_nack <= 1'b1;
            if (w_cmd_push) r_cmd_wr <= f_inc(r_cmd_wr);
            if (w_start)    r_cmd_rd <= f_inc(r_cmd_rd);
            if (w_cmd_push && !w_start)      r_cmd_cnt <= r_cmd_cnt + CW'(1);
            else if (!w_cmd_push && w_start) r_cmd_cnt <= r_cmd_cnt - CW'(1);
            if (w_rx_push) r_rx_wr <= f_inc(r_rx_wr);
            if (w_rx_pop)  r_rx_rd <= f_inc(r_rx_rd);
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wr] <= {w_a_rx, w_a_rx ? '0 : PWDATA};
        if (w_rx_push)  r_rx_mem[r_rx_wr]   <= r_data;
    end
endmodule

// File: tb/tb_apb_i2c.sv
// Directed bench for apb_i2c: APB register access plus a behavioural I2C slave at address 0x50.
module tb_apb_i2c;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable;
    logic        pready, pslverr, int_tx, int_rx, sda_en, scl_en;
    wire         sda_w, scl_w;
    int          n_tests = 0;
    int          n_fail  = 0;

    pullup (sda_w);
    pullup (scl_w);

    // Slave model state
    logic        sl_drive_low, sl_active, sl_ack_slot, sl_addr_ph, sl_rw, sl_acked, sl_master_ack;
    logic        p_scl, p_sda, sl_nack_addr;
    logic [7:0]  sl_sh, sl_addr_seen;
    logic [31:0] sl_rx_word, sl_tx_sh, sl_tx_word;
    int          sl_cnt, sl_nbytes;
    int          stop_cnt = 0;
    int          scl_cyc  = 0;
    logic [31:0] rx_q[$];

    assign sda_w = sl_drive_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    apb_i2c #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
        .PCLK(clk), .PRESETn(rst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
        .PSELx(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .INT_TX(int_tx), .INT_RX(int_rx), .SDA_ENABLE(sda_en), .SCL_ENABLE(scl_en),
        .SDA(sda_w), .SCL(scl_w)
    );

    always @(negedge clk) if (scl_en) scl_cyc <= scl_cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            sl_drive_low <= 1'b0; sl_active <= 1'b0; sl_ack_slot <= 1'b0; sl_addr_ph <= 1'b0;
            sl_rw <= 1'b0; sl_acked <= 1'b0; sl_master_ack <= 1'b0; sl_cnt <= 0; sl_nbytes <= 0;
            p_scl <= 1'b1; p_sda <= 1'b1;
        end else begin
            if (p_scl && scl_w && p_sda && !sda_w) begin
                sl_active <= 1'b1; sl_addr_ph <= 1'b1; sl_cnt <= 0; sl_ack_slot <= 1'b0;
                sl_drive_low <= 1'b0; sl_nbytes <= 0; sl_rx_word <= '0;
            end else if (p_scl && scl_w && !p_sda && sda_w) begin
                if (sl_active) begin
                    stop_cnt <= stop_cnt + 1;
                    if (!sl_rw && sl_nbytes == 4) rx_q.push_back(sl_rx_word);
                end
                sl_active <= 1'b0; sl_drive_low <= 1'b0;
            end else if (sl_active && !p_scl && scl_w) begin
                if (!sl_ack_slot) begin
                    sl_sh  <= {sl_sh[6:0], sda_w};
                    sl_cnt <= sl_cnt + 1;
                end else begin
                    sl_master_ack <= !sda_w;
                end
            end else if (sl_active && p_scl && !scl_w) begin
                if (sl_ack_slot) begin
                    sl_ack_slot <= 1'b0; sl_cnt <= 0; sl_addr_ph <= 1'b0;
                    if (sl_rw && ((sl_addr_ph && sl_acked) || (!sl_addr_ph && sl_master_ack))) begin
                        sl_drive_low <= !sl_tx_sh[31];
                        sl_tx_sh     <= sl_tx_sh << 1;
                    end else begin
                        sl_drive_low <= 1'b0;
                    end
                end else if (sl_cnt == 8) begin
                    sl_ack_slot <= 1'b1;
                    if (sl_addr_ph) begin
                        sl_addr_seen <= sl_sh;
                        sl_rw        <= sl_sh[0];
                        sl_acked     <= !sl_nack_addr && sl_sh[7:1] == 7'h50;
                        sl_drive_low <= !sl_nack_addr && sl_sh[7:1] == 7'h50;
                        sl_tx_sh     <= sl_tx_word;
                    end else if (!sl_rw) begin
                        sl_rx_word   <= {sl_rx_word[23:0], sl_sh};
                        sl_nbytes    <= sl_nbytes + 1;
                        sl_drive_low <= 1'b1;
                    end else begin
                        sl_nbytes    <= sl_nbytes + 1;
                        sl_drive_low <= 1'b0;
                    end
                end else if (sl_rw && !sl_addr_ph) begin
                    sl_drive_low <= !sl_tx_sh[31];
                    sl_tx_sh     <= sl_tx_sh << 1;
                end
            end
            p_scl <= scl_w;
            p_sda <= sda_w;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = wr; paddr = addr; pwdata = wdata; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_stops(input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (stop_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(posedge clk);
        #1;
        chk(tag, 32'(ok), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          target, c0;
    logic [31:0] words [4];

    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        sl_nack_addr = 1'b0; sl_tx_word = '0;
        words[0] = 32'h0102_0304; words[1] = 32'hDEAD_BEEF;
        words[2] = 32'h8000_0001; words[3] = 32'h5A5A_A5A5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_pready", 32'(pready), 32'h1);
        chk("rst_ints", {30'h0, int_tx, int_rx}, 32'h0);
        chk("rst_enables", {30'h0, sda_en, scl_en}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_enables", {28'h0, sda_en, scl_en, int_tx, int_rx}, 32'h0);
        apb(0, 32'h0C, 0, rd, er); chk("rst_status", rd, 32'h0C);
        apb(0, 32'h10, 0, rd, er); chk("rst_clkdiv", rd, 32'h4);
        apb(0, 32'h08, 0, rd, er); chk("rst_config", rd, 32'h0);

        // Error cases
        apb(0, 32'h04, 0, rd, er); chk("rx_empty_err", 32'(er), 32'h1);
        chk("rx_empty_prdata", rd, 32'h0);
        apb(0, 32'h14, 0, rd, er); chk("unmapped_err", 32'(er), 32'h1);
        apb(1, 32'h14, 32'h1, rd, er); chk("unmapped_wr_err", 32'(er), 32'h1);

        // Write transaction
        apb(1, 32'h08, 32'hA1, rd, er);
        apb(0, 32'h08, 0, rd, er); chk("config_rb", rd, 32'hA1);
        chk("int_tx_en_empty", 32'(int_tx), 32'h1);
        target = stop_cnt + 1;
        c0 = scl_cyc;
        apb(1, 32'h00, 32'hA5C3_1E77, rd, er); chk("tx_wr_err", 32'(er), 32'h0);
        chk("int_tx_after_push", 32'(int_tx), 32'h0);
        wait_stops(target, "tx_stop_timeout");
        chk("tx_addr", 32'(sl_addr_seen), 32'hA0);
        chk("tx_words", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("tx_data", rx_q[0], 32'hA5C3_1E77);
        chk("tx_scl_cycles", 32'(scl_cyc - c0), 32'd940);
        chk("int_tx_back", 32'(int_tx), 32'h1);
        apb(0, 32'h0C, 0, rd, er); chk("tx_status", rd, 32'h0C);

        // Read transaction
        sl_tx_word = 32'h1234_5678;
        target = stop_cnt + 1;
        apb(1, 32'h04, 32'hFFFF_FFFF, rd, er); chk("rd_req_err", 32'(er), 32'h0);
        wait_stops(target, "rd_stop_timeout");
        chk("rd_addr", 32'(sl_addr_seen), 32'hA1);
        chk("int_rx_set", 32'(int_rx), 32'h1);
        apb(0, 32'h0C, 0, rd, er); chk("rd_status", rd, 32'h04);
        apb(0, 32'h04, 0, rd, er); chk("rd_data", rd, 32'h1234_5678);
        chk("rd_pslverr", 32'(er), 32'h0);
        chk("int_rx_clr", 32'(int_rx), 32'h0);

        // Faster bit clock
        apb(1, 32'h10, 32'h1, rd, er);
        apb(0, 32'h10, 0, rd, er); chk("clkdiv_rb", rd, 32'h1);
        target = stop_cnt + 1;
        c0 = scl_cyc;
        apb(1, 32'h00, 32'h3C3C_0F0F, rd, er);
        wait_stops(target, "div1_stop_timeout");
        chk("div1_scl_cycles", 32'(scl_cyc - c0), 32'd376);
        if (rx_q.size() > 1) chk("div1_data", rx_q[1], 32'h3C3C_0F0F);
        else chk("div1_words", 32'(rx_q.size()), 32'd2);
        apb(1, 32'h10, 32'h4, rd, er);

        // Fill the command FIFO while disabled
        rx_q.delete();
        apb(1, 32'h08, 32'hA0, rd, er);
        for (int i = 0; i < 4; i++) begin
            apb(1, 32'h00, words[i], rd, er);
            chk("fill_err", 32'(er), 32'h0);
        end
        apb(1, 32'h00, 32'hFFFF_FFFF, rd, er); chk("fifth_err", 32'(er), 32'h1);
        apb(1, 32'h04, 32'h0, rd, er); chk("rdreq_full_err", 32'(er), 32'h1);
        apb(0, 32'h0C, 0, rd, er); chk("full_status", rd, 32'h0A);
        chk("int_tx_dis", 32'(int_tx), 32'h0);
        target = stop_cnt + 4;
        apb(1, 32'h08, 32'hA1, rd, er);
        wait_stops(target, "burst_timeout");
        chk("burst_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size()) chk("burst_word", rx_q[i], words[i]);

        // Address NACK
        sl_nack_addr = 1'b1;
        target = stop_cnt + 1;
        apb(1, 32'h00, 32'h0BAD_F00D, rd, er);
        wait_stops(target, "nack_timeout");
        apb(0, 32'h0C, 0, rd, er); chk("nack_status", rd, 32'h2C);
        chk("nack_no_word", 32'(rx_q.size()), 32'd4);
        apb(1, 32'h0C, 32'h20, rd, er);
        apb(0, 32'h0C, 0, rd, er); chk("nack_cleared", rd, 32'h0C);
        sl_nack_addr = 1'b0;

        // Reset during the data phase
        apb(1, 32'h00, 32'h7777_8888, rd, er);
        repeat (260) @(posedge clk);
        #1;
        chk("mid_busy", {30'h0, sda_en | scl_en, scl_en}, 32'h3);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_enables", {30'h0, sda_en, scl_en}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apb(0, 32'h0C, 0, rd, er); chk("post_rst_status", rd, 32'h0C);
        apb(0, 32'h08, 0, rd, er); chk("post_rst_config", rd, 32'h0);
        chk("post_rst_enables", {30'h0, sda_en, scl_en}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
